uart_rx_os16: RTL and testbench

UART_RX_OS16 -- requirements
Module: uart_rx_os16

---
 rtl/uart_rx_os16.sv | 145 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8-bit UART receiver sampling on a x16 oversampling enable tick; LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7 (reported on parity_err).
module uart_rx_os16 #(
  parameter int OS_RATE    = 16,
  parameter int MID_SAMPLE = 7
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       serial_clk,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int TW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par_bad;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = STOP;
  assign parity_err = 1'b0;
`endif

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          sync1, sync2;

  // rx_in is asynchronous; the FSM only ever looks at sync2
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      // status flags are single-cycle pulses regardless of tick timing
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (serial_clk) begin
        case (state)
          IDLE: begin
            if (!sync2) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= sync2 ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {sync2, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= AFTER_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_bad  <= sync2 ^ (^shift_reg);
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
              if (sync2) begin
                if (!par_bad) begin
                  data_out   <= shift_reg;
                  data_valid <= 1'b1;
                end
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
`else
              if (sync2) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
`endif
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          // a held-low line (break) stays here so it reports only one frame_err
          WAIT_IDLE: begin
            if (sync2) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized bench for uart_rx_os16: drives serial frames and compares against a frame-level model.
module tb_uart_rx_os16;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_clk = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err;

  int checks = 0;
  int errors = 0;
  int n_fe = 0, n_pe = 0, exp_fe = 0, exp_pe = 0;
  logic [7:0] exp_last = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic prev_dv = 1'b0;

  uart_rx_os16 #(.OS_RATE(OS), .MID_SAMPLE(7)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .serial_clk(serial_clk), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk_in = ~clk_in;

  // one enable tick every 4 clocks
  initial forever begin
    repeat (3) @(posedge clk_in);
    #1 serial_clk = 1'b1;
    @(posedge clk_in);
    #1 serial_clk = 1'b0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // monitor: record every accepted byte and every error pulse
  initial forever begin
    @(negedge clk_in);
    if (rst_n) begin
      if (data_valid) begin
        got_q.push_back(data_out);
        check("dv_excl", {30'd0, frame_err, parity_err}, 32'd0);
        check("dv_width", {31'd0, prev_dv}, 32'd0);
      end
      if (frame_err) n_fe++;
      if (parity_err) n_pe++;
    end
    prev_dv = data_valid;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      while (!serial_clk) @(posedge clk_in);
    end
    #1;
  endtask

  task automatic line(input logic v, input int n);
    rx_in = v;
    wait_ticks(n);
  endtask

  // drive one frame and update the reference model from the frame rules
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    logic ok;
    logic pbit;
    pbit = (^b) ^ bad_par;
    line(1'b0, OS);
    for (int i = 0; i < 8; i++) line(b[i], OS);
    if (PAR_EN) line(pbit, OS);
    line(stop, OS);
    ok = 1'b1;
    if (PAR_EN && bad_par) begin exp_pe++; ok = 1'b0; end
    if (!stop) begin exp_fe++; ok = 1'b0; end
    if (ok) begin
      exp_q.push_back(b);
      exp_last = b;
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    check({tag, "_frame_err"}, n_fe, exp_fe);
    check({tag, "_parity_err"}, n_pe, exp_pe);
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_last));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs, rp;
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    line(1'b1, 4);

    send_frame(8'h55, 1'b1, 1'b0);
    line(1'b1, 4);
    verify("f55");

    line(1'b0, 4);
    line(1'b1, 30);
    verify("false_start");
    send_frame(8'hA3, 1'b1, 1'b0);
    line(1'b1, 4);
    verify("fA3");

    send_frame(8'h3C, 1'b0, 1'b0);
    line(1'b0, 40);
    line(1'b1, 6);
    verify("break");

    // reset after D3 of 0xFF
    line(1'b0, OS);
    for (int i = 0; i < 4; i++) line(1'b1, OS);
    rst_n = 1'b0;
    @(negedge clk_in);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_parity_err", {31'd0, parity_err}, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    exp_last = 8'h00;
    line(1'b1, 20);
    verify("after_rst");
    send_frame(8'h81, 1'b1, 1'b0);
    line(1'b1, 4);
    verify("f81");

`ifdef UART_RX_PARITY_EN
    send_frame(8'hA3, 1'b1, 1'b1);
    line(1'b1, 4);
    verify("par_bad");
    send_frame(8'hA3, 1'b1, 1'b0);
    line(1'b1, 4);
    verify("par_good");
`endif

    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    line(1'b1, 4);
    verify("b2b");

    for (int k = 0; k < 14; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 3) == 0);
      send_frame(rb, rs, rp);
      if (!rs) begin
        line(1'b0, $urandom_range(0, 20));
        line(1'b1, $urandom_range(3, 10));
      end else begin
        line(1'b1, $urandom_range(0, 6));
      end
      verify("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
